spi_txn_arbiter: RTL
====================

Name: spi_txn_arbiter

Overview:
Transaction-level controller that shares one 8-bit SPI byte engine among NREQ requesters and sequences multi-byte transfers on it.
- Round-robin arbitration between requesters.
- Asserts the selected slave-select line with programmable setup/hold gaps.
- Applies that slave's stored mode/divider configuration.
- Streams TX bytes in and RX bytes out per requester.
- Sits between on-chip clients (AXI-lite core, DMA, sensor pollers) and the Spi byte engine.

Parameters:
- NREQ, 2, number of requesters.
- NSLAVE, 2, number of slave-select lines.
- SS_W, 1, width of slave index; NSLAVE <= 2**SS_W.
- LEN_W, 4, byte-count field width; length field = bytes-1, max 2**LEN_W bytes.
- CS_SETUP, 4, clk cycles from ss_n low to first spi_start.
- CS_HOLD, 4, clk cycles from last spi_done_tick to ss_n high.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester transaction request, level
- req_ss  in  NREQ*SS_W  packed slave index per requester
- req_len  in  NREQ*LEN_W  packed byte count minus one per requester
- gnt  out  NREQ  one-hot grant, held for the whole transaction
- tx_data  in  NREQ*8  packed TX byte per requester
- tx_valid  in  NREQ  TX byte valid
- tx_ready  out  NREQ  TX byte accepted when tx_valid & tx_ready
- rx_data  out  8  last received byte, shared bus
- rx_valid  out  NREQ  one-cycle pulse to granted requester when rx_data updates
- done  out  NREQ  one-cycle pulse at transaction end
- err  out  1  one-cycle pulse on an illegal slave index
- busy  out  1  high when state != IDLE
- cfg_we  in  1  config write strobe
- cfg_sel  in  SS_W  slave whose config is written
- cfg_wdata  in  18  [15:0] dvsr, [16] cpol, [17] cpha
- spi_start  out  1  one-cycle start to byte engine
- spi_din  out  8  TX byte to engine
- spi_dvsr, spi_cpol, spi_cpha  out  16/1/1  active mode to engine
- spi_dout  in  8  RX byte from engine
- spi_done_tick  in  1  byte-complete pulse from engine
- spi_ready  in  1  engine idle
- spi_ss_n  out  NSLAVE  active-low slave selects

Behaviour:
- Reset (async):
  - Per-slave config = 18'h0_0200 (dvsr 0x200, cpol 0, cpha 0).
  - spi_ss_n all ones.
  - All pulses, gnt, tx_ready, spi_start = 0.
  - rx_data = 0; RR pointer = 0; state IDLE.
  - Reset mid-transfer drops ss_n high immediately. No done pulse.
- Config: cfg_we writes cfg[cfg_sel] every cycle, in any state; cfg_sel >= NSLAVE is ignored. Active config is latched at grant, so a write to the active slave takes effect on its next transaction.
- FSM: IDLE -> ARB -> SETUP -> LOAD -> START -> XFER -> (LOAD | HOLD) -> IDLE.
  - IDLE: when any req is high, go to ARB.
  - ARB (1 cycle): pick the first req at or after the RR pointer, with wrap. Latch index g, req_ss, req_len into byte counter, and cfg[req_ss]. Assert gnt[g].
    - If req_ss >= NSLAVE: pulse err and done[g], drop gnt, return to IDLE. No SS asserted, no bytes transferred.
  - SETUP: spi_ss_n[ss] = 0; wait CS_SETUP cycles.
  - LOAD: tx_ready[g] = 1. On handshake, capture the byte into spi_din and go to START. Waits indefinitely otherwise (see optional feature).
  - START: when spi_ready, pulse spi_start for 1 cycle, then go to XFER. If the engine is not ready, hold.
  - XFER: on spi_din-driven spi_done_tick, rx_data <= spi_dout and pulse rx_valid[g] the next cycle. If counter == 0, go to HOLD; else decrement and go to LOAD.
  - HOLD: wait CS_HOLD cycles, then ss_n all ones. Pulse done[g], drop gnt, set RR pointer = g+1 mod NREQ, go to IDLE.
- Latency and ordering:
  - Minimum one idle cycle between transactions.
  - Deassertion of req after grant is ignored; the transaction runs the full length.
  - A requester holding req continuously gets at most every NREQth slot when others request.
  - Only one ss_n bit is ever low.
  - spi_dvsr/cpol/cpha change only in ARB, i.e. while ss_n is high.

Optional Feature:
- SPI_ARB_TIMEOUT_EN:
  - When defined, a 16-bit watchdog counts LOAD cycles without a handshake.
  - At 0xFFFF the transaction aborts: go to HOLD, pulse err with done[g], and reset the RR pointer as normal.
  - When undefined, LOAD waits forever and err fires only on an illegal slave index.

Decomposition:
- Shared package spi_pkg:
  - FSM state encoding.
  - Config field offsets (DVSR_LSB 0, CPOL_BIT 16, CPHA_BIT 17).
  - Reset config constant 18'h0_0200.
- One natural sub-module: rr_arbiter (NREQ-wide round-robin, inputs req/pointer, output one-hot grant and index). Reusable elsewhere.

Test Plan:
- Single requester 0, req_ss 1, req_len 2, TX A5 3C FF, loopback miso = mosi:
  - ss_n goes 2'b01 for the transfer.
  - rx_valid[0] pulses 3 times with A5, 3C, FF.
  - done[0] pulses once; ss_n returns to 2'b11.
- Both requesters hold req continuously, 1-byte transfers:
  - gnt alternates 01, 10, 01, 10.
  - No overlap; ss_n never has two bits low.
- cfg write slave 0 = 18'h3_0004 during requester 1's transfer to slave 0:
  - The current transfer keeps dvsr 0x200.
  - The next one uses dvsr 4, cpol 1, cpha 1.
- req_ss = 3 with NSLAVE 2 (SS_W 2): err and done pulse in the cycle after ARB; spi_start is never asserted; ss_n stays 2'b11.
- Reset asserted during XFER of byte 2 of 4:
  - ss_n goes 2'b11 asynchronously; gnt = 0; no done.
  - After release, a new transaction completes normally.
- With SPI_ARB_TIMEOUT_EN, tx_valid held 0 after the first byte: after 65535 LOAD cycles err and done fire, and ss_n is released CS_HOLD cycles later.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transaction arbiter:
// FSM state encoding, per-slave config field layout and reset config.
package spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SETUP,
        S_LOAD,
        S_START,
        S_XFER,
        S_HOLD
    } state_t;

    localparam int CFG_W    = 18;
    localparam int DVSR_LSB = 0;
    localparam int CPOL_BIT = 16;
    localparam int CPHA_BIT = 17;

    localparam logic [CFG_W-1:0] CFG_RST = 18'h0_0200;

    function automatic logic [15:0] cfg_dvsr(input logic [CFG_W-1:0] c);
        return c[DVSR_LSB +: 16];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active req at or after ptr.
// Ports: req, ptr in; gnt (one-hot), idx, found out.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI byte engine among NREQ requesters: round-robin grant,
// slave-select with setup/hold gaps, per-slave mode/divider, byte streaming.
// Ports: req/req_ss/req_len/gnt, tx_*/rx_*, done/err/busy, cfg_* write port,
// spi_* engine interface, spi_ss_n selects.
// Optional: SPI_ARB_TIMEOUT_EN adds a 16-bit LOAD watchdog that aborts
// a transaction stuck waiting for TX data.
module spi_txn_arbiter
    import spi_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int NSLAVE   = 2,
    parameter int SS_W     = 1,
    parameter int LEN_W    = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*SS_W-1:0]  req_ss,
    input  logic [NREQ*LEN_W-1:0] req_len,
    output logic [NREQ-1:0]       gnt,
    input  logic [NREQ*8-1:0]     tx_data,
    input  logic [NREQ-1:0]       tx_valid,
    output logic [NREQ-1:0]       tx_ready,
    output logic [7:0]            rx_data,
    output logic [NREQ-1:0]       rx_valid,
    output logic [NREQ-1:0]       done,
    output logic                  err,
    output logic                  busy,
    input  logic                  cfg_we,
    input  logic [SS_W-1:0]       cfg_sel,
    input  logic [CFG_W-1:0]      cfg_wdata,
    output logic                  spi_start,
    output logic [7:0]            spi_din,
    output logic [15:0]           spi_dvsr,
    output logic                  spi_cpol,
    output logic                  spi_cpha,
    input  logic [7:0]            spi_dout,
    input  logic                  spi_done_tick,
    input  logic                  spi_ready,
    output logic [NSLAVE-1:0]     spi_ss_n
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NCFG  = 2 ** SS_W;

    state_t state, state_nxt;

    logic [IDX_W-1:0]  rr_ptr, g_q, arb_idx;
    logic [NREQ-1:0]   arb_gnt, gnt_q, done_q, rx_valid_q;
    logic              arb_found, arb_legal;
    logic              tx_hs, wd_expire, err_q, aborted_q;
    logic [SS_W-1:0]   arb_ss;
    logic [LEN_W-1:0]  arb_len, cnt_q;
    logic [15:0]       tmr_q;
    logic [CFG_W-1:0]  cfg_q [NCFG];
    logic [CFG_W-1:0]  act_cfg;
    logic [NSLAVE-1:0] ss_n_q;
    logic [7:0]        din_q, rx_q;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDX_W(IDX_W)
    ) u_rr (
        .req  (req),
        .ptr  (rr_ptr),
        .gnt  (arb_gnt),
        .idx  (arb_idx),
        .found(arb_found)
    );

    assign arb_ss    = req_ss[arb_idx*SS_W +: SS_W];
    assign arb_len   = req_len[arb_idx*LEN_W +: LEN_W];
    assign arb_legal = 32'(arb_ss) < NSLAVE;
    assign tx_hs     = (state == S_LOAD) && tx_valid[g_q];

`ifdef SPI_ARB_TIMEOUT_EN
    assign wd_expire = (state == S_LOAD) && !tx_hs && (tmr_q == 16'hFFFF);
`else
    assign wd_expire = 1'b0;
`endif

    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
        return (g == IDX_W'(NREQ - 1)) ? '0 : g + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_ready  = '0;
        spi_start = 1'b0;
        busy      = (state != S_IDLE);
        unique case (state)
            S_IDLE:  if (|req) state_nxt = S_ARB;
            S_ARB:   state_nxt = (arb_found && arb_legal) ? S_SETUP : S_IDLE;
            S_SETUP: if (tmr_q == 16'(CS_SETUP - 1)) state_nxt = S_LOAD;
            S_LOAD: begin
                tx_ready = gnt_q;
                if (tx_hs)          state_nxt = S_START;
                else if (wd_expire) state_nxt = S_HOLD;
            end
            S_START: begin
                spi_start = spi_ready;
                if (spi_ready) state_nxt = S_XFER;
            end
            S_XFER: begin
                if (spi_done_tick)
                    state_nxt = (cnt_q == '0) ? S_HOLD : S_LOAD;
            end
            S_HOLD:  if (tmr_q == 16'(CS_HOLD - 1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NCFG; i++) cfg_q[i] <= CFG_RST;
            act_cfg    <= CFG_RST;
            rr_ptr     <= '0;
            g_q        <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            rx_valid_q <= '0;
            err_q      <= 1'b0;
            aborted_q  <= 1'b0;
            cnt_q      <= '0;
            tmr_q      <= '0;
            ss_n_q     <= '1;
            din_q      <= '0;
            rx_q       <= '0;
        end else begin
            done_q     <= '0;
            rx_valid_q <= '0;
            err_q      <= 1'b0;

            if (cfg_we && (32'(cfg_sel) < NSLAVE))
                cfg_q[cfg_sel] <= cfg_wdata;

            // One shared timer: SETUP/HOLD gaps and the LOAD watchdog.
            if (state_nxt != state) tmr_q <= '0;
            else                    tmr_q <= tmr_q + 16'd1;

            if (state == S_ARB && arb_found) begin
                g_q   <= arb_idx;
                cnt_q <= arb_len;
                if (arb_legal) begin
                    gnt_q   <= arb_gnt;
                    act_cfg <= cfg_q[arb_ss];
                    ss_n_q  <= ~(NSLAVE'(1) << arb_ss);
                end else begin
                    // Rejected request still yields its turn.
                    err_q  <= 1'b1;
                    done_q <= arb_gnt;
                    rr_ptr <= ptr_after(arb_idx);
                end
            end

            if (tx_hs) din_q <= tx_data[g_q*8 +: 8];

            if (wd_expire) begin
                err_q     <= 1'b1;
                done_q    <= gnt_q;
                aborted_q <= 1'b1;
            end

            if (state == S_XFER && spi_done_tick) begin
                rx_q       <= spi_dout;
                rx_valid_q <= gnt_q;
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end

            if (state == S_HOLD && state_nxt == S_IDLE) begin
                ss_n_q    <= '1;
                gnt_q     <= '0;
                done_q    <= aborted_q ? '0 : gnt_q;
                aborted_q <= 1'b0;
                rr_ptr    <= ptr_after(g_q);
            end
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_q;
    assign spi_din  = din_q;
    assign spi_ss_n = ss_n_q;
    assign spi_dvsr = cfg_dvsr(act_cfg);
    assign spi_cpol = act_cfg[CPOL_BIT];
    assign spi_cpha = act_cfg[CPHA_BIT];

endmodule
